// File: rtl/arbitro_mux_4_if.sv
// Request/grant/select bundle between the requesters and the mux-select arbiter.
interface arbitro_mux_4_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       S0;
    logic       S1;
    logic       busy;

    modport master (output req, input grant, input S0, input S1, input busy);
    modport slave  (input req, output grant, output S0, output S1, output busy);
endinterface

// File: rtl/arbitro_mux_4.sv
// Round-robin owner sequencer for the shared 4:1 ULA mux select lines.
// Holds S1/S0 across dead cycles so the path only moves on a fresh grant.
module arbitro_mux_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    arbitro_mux_4_if.slave  bus
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               busy_q, busy_d;

    logic               pick_vld_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic [IDX_W-1:0]   cand_c;
    logic               contend_c;

    // Search last+1, last+2, last+3, last; first requester found wins.
    always_comb begin
        pick_vld_c = 1'b0;
        pick_idx_c = last_q;
        cand_c     = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand_c = last_q + IDX_W'(k);
            if (!pick_vld_c && bus.req[cand_c]) begin
                pick_vld_c = 1'b1;
                pick_idx_c = cand_c;
            end
        end
    end

    assign contend_c = |(bus.req & ~grant_q);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        sel_d      = sel_q;

        unique case (state_q)
            ST_IDLE, ST_RELEASE: begin
                grant_d = '0;
                if (pick_vld_c) begin
                    state_d    = ST_GRANT;
                    owner_d    = pick_idx_c;
                    grant_d    = N_REQ'(1) << pick_idx_c;
                    sel_d      = pick_idx_c;
                    hold_cnt_d = CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // Owner dropping wins over preemption; both give one RELEASE.
                if (!bus.req[owner_q] || ((hold_cnt_q == HOLD_MAX) && contend_c)) begin
                    state_d = ST_RELEASE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            last_q     <= IDX_W'(3);
            hold_cnt_q <= '0;
            grant_q    <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.S0    = sel_q[0];
    assign bus.S1    = sel_q[1];
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_arbitro_mux_4.sv
// Bench for arbitro_mux_4: two instances (MAX_HOLD 4 and 1) against a cycle model.
module tb_arbitro_mux_4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arbitro_mux_4_if bus_a ();
    arbitro_mux_4_if bus_b ();

    arbitro_mux_4 #(.MAX_HOLD(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    arbitro_mux_4 #(.MAX_HOLD(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    int n_vec = 0;
    int n_err = 0;

    // phase: 0 = nobody owns the path, 1 = owner granted, 2 = dead cycle
    typedef struct {
        int phase;
        int owner;
        int last;
        int held;
        int sel;
    } mdl_t;

    mdl_t ma, mb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_init();
        mdl_t m;
        m.phase = 0; m.owner = 0; m.last = 3; m.held = 0; m.sel = 0;
        return m;
    endfunction

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (last + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] r, input int mx);
        mdl_t n;
        logic [3:0] own_mask;
        int p;
        n = m;
        if (m.phase == 1) begin
            own_mask = 4'b0001 << m.owner;
            if (!r[m.owner] || (m.held >= mx && (r & ~own_mask) != 4'b0000)) begin
                n.phase = 2;
                n.last  = m.owner;
            end else begin
                n.held = m.held + 1;
            end
        end else begin
            p = rr_pick(r, m.last);
            if (p >= 0) begin
                n.phase = 1; n.owner = p; n.sel = p; n.held = 1;
            end else begin
                n.phase = 0;
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_grant(input mdl_t m);
        logic [3:0] g;
        g = 4'b0001 << m.owner;
        return (m.phase == 1) ? g : 4'b0000;
    endfunction

    task automatic compare_all();
        chk("a_grant", 32'(bus_a.grant), 32'(exp_grant(ma)));
        chk("a_sel",   32'({bus_a.S1, bus_a.S0}), 32'(ma.sel));
        chk("a_busy",  32'(bus_a.busy), 32'(ma.phase != 0));
        chk("b_grant", 32'(bus_b.grant), 32'(exp_grant(mb)));
        chk("b_sel",   32'({bus_b.S1, bus_b.S0}), 32'(mb.sel));
        chk("b_busy",  32'(bus_b.busy), 32'(mb.phase != 0));
    endtask

    // Drive req from a negedge, clock it in, then compare at the next negedge.
    task automatic cycle(input logic [3:0] r);
        bus_a.req = r;
        bus_b.req = r;
        @(posedge clk);
        ma = mdl_step(ma, r, 4);
        mb = mdl_step(mb, r, 1);
        @(negedge clk);
        compare_all();
    endtask

    // Called at a negedge; reset lands mid-cycle and must clear with no edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_a_grant", 32'(bus_a.grant), 32'd0);
        chk("rst_a_sel",   32'({bus_a.S1, bus_a.S0}), 32'd0);
        chk("rst_a_busy",  32'(bus_a.busy), 32'd0);
        chk("rst_b_grant", 32'(bus_b.grant), 32'd0);
        ma = mdl_init();
        mb = mdl_init();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        rst_n     = 1'b0;
        bus_a.req = 4'b0000;
        bus_b.req = 4'b0000;
        ma = mdl_init();
        mb = mdl_init();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) cycle(4'b0000);

        // Single requester, three grant cycles then drop.
        cycle(4'b0100);
        chk("t2_grant", 32'(bus_a.grant), 32'h4);
        chk("t2_sel", 32'({bus_a.S1, bus_a.S0}), 32'd2);
        cycle(4'b0100);
        cycle(4'b0100);
        cycle(4'b0000);
        chk("t2_dead_grant", 32'(bus_a.grant), 32'h0);
        chk("t2_dead_sel", 32'({bus_a.S1, bus_a.S0}), 32'd2);
        chk("t2_dead_busy", 32'(bus_a.busy), 32'd1);
        cycle(4'b0000);
        chk("t2_idle_busy", 32'(bus_a.busy), 32'd0);

        // Fair rotation under full contention.
        for (int i = 0; i < 30; i++) cycle(4'b1111);

        // Priority right after reset.
        do_reset();
        cycle(4'b1010);
        chk("t4_first", 32'(bus_a.grant), 32'h2);
        cycle(4'b1010);
        cycle(4'b1000);
        chk("t4_dead", 32'(bus_a.grant), 32'h0);
        cycle(4'b1000);
        chk("t4_next", 32'(bus_a.grant), 32'h8);

        // Uncontended hold, then contention forces a handover.
        do_reset();
        for (int i = 0; i < 20; i++) cycle(4'b0001);
        chk("t5_hold", 32'(bus_a.grant), 32'h1);
        cycle(4'b1001);
        chk("t5_preempt", 32'(bus_a.grant), 32'h0);
        cycle(4'b1001);
        chk("t5_next", 32'(bus_a.grant), 32'h8);

        // Reset while requester 2 owns the path.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (ma.phase == 1 && ma.owner == 2) break;
            cycle(4'b1111);
        end
        chk("t6_pre", 32'(bus_a.grant), 32'h4);
        do_reset();
        cycle(4'b1111);
        chk("t6_first", 32'(bus_a.grant), 32'h1);

        // Randomized sticky requests with occasional mid-cycle resets.
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            if ($urandom_range(199) == 0) do_reset();
            cycle(r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
